// File: rtl/ppu_sprite_pkg.sv
// Shared constants and helpers for the PPU sprite output stage.
package ppu_sprite_pkg;

    localparam int SPRITE_SLOTS  = 8;

    localparam int ATTR_PAL_LO   = 0;
    localparam int ATTR_PRIORITY = 5;
    localparam int ATTR_FLIP_H   = 6;
    localparam int ATTR_FLIP_V   = 7;

    localparam logic [8:0] VIS_FIRST_DOT      = 9'd1;
    localparam logic [8:0] VIS_LAST_DOT       = 9'd256;
    localparam logic [8:0] CLEAR_DOT          = 9'd257;
    localparam logic [8:0] LEFT_CLIP_LAST_DOT = 9'd8;

    function automatic logic [7:0] bit_reverse8(input logic [7:0] value);
        logic [7:0] result;
        for (int i = 0; i < 8; i++) begin
            result[i] = value[7-i];
        end
        return result;
    endfunction

endpackage

// File: rtl/sprite_output_unit.sv
// One sprite slot: X down-counter, pattern shifters, palette/priority attributes
// and the sprite-0 flag. The pixel output is combinational from slot state.
module sprite_output_unit
    import ppu_sprite_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ce,
    input  logic       i_clear,
    input  logic       i_render,
    input  logic       i_load,
    input  logic [7:0] i_load_attr,
    input  logic [7:0] i_load_x,
    input  logic [7:0] i_load_lo,
    input  logic [7:0] i_load_hi,
    input  logic       i_sprite0,
    output logic [1:0] o_pixel,
    output logic [1:0] o_palette,
    output logic       o_priority,
    output logic       o_sprite0
);

    logic [7:0] lo_r;
    logic [7:0] hi_r;
    logic [7:0] x_cnt_r;
    logic [1:0] palette_r;
    logic       priority_r;
    logic       sprite0_r;

    logic [7:0] lo_load_s;
    logic [7:0] hi_load_s;
    logic       unused_attr_s;

    // Vertical flip and the unimplemented attribute bits are resolved upstream.
    assign unused_attr_s = ^{i_load_attr[ATTR_FLIP_V], i_load_attr[4:2]};

    // Horizontal flip reverses the planes once at load so the shifter stays MSB-first.
    always_comb begin
        lo_load_s = i_load_lo;
        hi_load_s = i_load_hi;
        if (i_load_attr[ATTR_FLIP_H]) begin
            lo_load_s = bit_reverse8(i_load_lo);
            hi_load_s = bit_reverse8(i_load_hi);
        end else begin
            lo_load_s = i_load_lo;
            hi_load_s = i_load_hi;
        end
    end

    // Slot state: load beats the end-of-row clear, rendering counts down then shifts.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lo_r       <= 8'h00;
            hi_r       <= 8'h00;
            x_cnt_r    <= 8'h00;
            palette_r  <= 2'b00;
            priority_r <= 1'b0;
            sprite0_r  <= 1'b0;
        end else if (i_ce) begin
            if (i_load) begin
                lo_r       <= lo_load_s;
                hi_r       <= hi_load_s;
                x_cnt_r    <= i_load_x;
                palette_r  <= i_load_attr[ATTR_PAL_LO +: 2];
                priority_r <= i_load_attr[ATTR_PRIORITY];
                sprite0_r  <= i_sprite0;
            end else if (i_clear) begin
                lo_r       <= 8'h00;
                hi_r       <= 8'h00;
                x_cnt_r    <= 8'h00;
                palette_r  <= 2'b00;
                priority_r <= 1'b0;
                sprite0_r  <= 1'b0;
            end else if (i_render) begin
                if (x_cnt_r != 8'h00) begin
                    x_cnt_r <= x_cnt_r - 8'd1;
                end else begin
                    lo_r <= {lo_r[6:0], 1'b0};
                    hi_r <= {hi_r[6:0], 1'b0};
                end
            end
        end
    end

    assign o_pixel    = (x_cnt_r == 8'h00) ? {hi_r[7], lo_r[7]} : 2'b00;
    assign o_palette  = palette_r;
    assign o_priority = priority_r;
    assign o_sprite0  = sprite0_r && (o_pixel != 2'b00);

endmodule

// File: rtl/sprite_output_units.sv
// Eight sprite slots, lowest-slot-wins pixel select, masking and registered outputs.
// Optional build macro: PPU_SPRITE_LEFT_CLIP_EN (honour i_show_left8 for columns 0-7).
module sprite_output_units
    import ppu_sprite_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ce,
    input  logic [8:0] i_video_x,
    input  logic       i_is_rendering_sprites_enabled,
    input  logic       i_show_left8,
    input  logic       i_load,
    input  logic [2:0] i_load_slot,
    input  logic [7:0] i_load_attr,
    input  logic [7:0] i_load_x,
    input  logic [7:0] i_load_lo,
    input  logic [7:0] i_load_hi,
    input  logic       i_sprite0_in_slot0,
    output logic [3:0] o_palette_index,
    output logic       o_priority,
    output logic       o_sprite0_opaque
);

    logic                    render_s;
    logic                    clear_s;
    logic                    clip_s;
    logic [1:0]              pixel_s    [SPRITE_SLOTS];
    logic [1:0]              palette_s  [SPRITE_SLOTS];
    logic [SPRITE_SLOTS-1:0] prio_s;
    logic [SPRITE_SLOTS-1:0] slot_sprite0_s;
    logic                    sprite0_s;
    logic                    unused_sprite0_s;
    logic [3:0]              win_index_s;
    logic                    win_prio_s;

    assign render_s = (i_video_x >= VIS_FIRST_DOT) && (i_video_x <= VIS_LAST_DOT);
    assign clear_s  = (i_video_x == CLEAR_DOT);

`ifdef PPU_SPRITE_LEFT_CLIP_EN
    assign clip_s = !i_show_left8 && (i_video_x <= LEFT_CLIP_LAST_DOT);
`else
    logic unused_show_left8_s;
    assign unused_show_left8_s = i_show_left8;
    assign clip_s = 1'b0;
`endif

    for (genvar g = 0; g < SPRITE_SLOTS; g++) begin : g_slot
        sprite_output_unit u_slot (
            .i_clk       (i_clk),
            .i_reset     (i_reset),
            .i_ce        (i_ce),
            .i_clear     (clear_s),
            .i_render    (render_s),
            .i_load      (i_load && (i_load_slot == 3'(g))),
            .i_load_attr (i_load_attr),
            .i_load_x    (i_load_x),
            .i_load_lo   (i_load_lo),
            .i_load_hi   (i_load_hi),
            .i_sprite0   ((g == 0) ? i_sprite0_in_slot0 : 1'b0),
            .o_pixel     (pixel_s[g]),
            .o_palette   (palette_s[g]),
            .o_priority  (prio_s[g]),
            .o_sprite0   (slot_sprite0_s[g])
        );
    end

    // Only slot 0 can hold sprite 0; the other flags are constant zero.
    assign sprite0_s        = slot_sprite0_s[0];
    assign unused_sprite0_s = ^slot_sprite0_s[SPRITE_SLOTS-1:1];

    // Scan from the highest slot down so the lowest opaque slot is written last.
    always_comb begin
        win_index_s = 4'd0;
        win_prio_s  = 1'b0;
        for (int i = SPRITE_SLOTS - 1; i >= 0; i--) begin
            if (pixel_s[i] != 2'b00) begin
                win_index_s = {palette_s[i], pixel_s[i]};
                win_prio_s  = prio_s[i];
            end else begin
                win_index_s = win_index_s;
                win_prio_s  = win_prio_s;
            end
        end
    end

    // Output register: visible, enabled, unclipped dots pass the winner, else transparent.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_palette_index  <= 4'd0;
            o_priority       <= 1'b0;
            o_sprite0_opaque <= 1'b0;
        end else if (i_ce) begin
            if (render_s && i_is_rendering_sprites_enabled && !clip_s) begin
                o_palette_index  <= win_index_s;
                o_priority       <= win_prio_s;
                o_sprite0_opaque <= sprite0_s;
            end else begin
                o_palette_index  <= 4'd0;
                o_priority       <= 1'b0;
                o_sprite0_opaque <= 1'b0;
            end
        end
    end

endmodule

// File: doc/sprite_output_units.md
# sprite_output_units

Sprite rasterisation stage of the PPU, directly downstream of the sprite fetch logic. Holds the eight per-slot pattern shift registers, X counters and attributes loaded during cycles 257-320. During the following scanline's visible cycles 1-256 it selects the highest-priority opaque sprite pixel, producing the sprite palette index, background-priority flag and sprite-0 opacity flag for the pixel combiner.

## Interface
- Parameters: none. Slot count and attribute bit positions live in the shared package.
- i_clk  in  1  PPU clock.
- i_reset  in  1  Synchronous, active-high reset.
- i_ce  in  1  Clock enable; state advances only when high.
- i_video_x  in  9  Current dot, 0-340.
- i_is_rendering_sprites_enabled  in  1  PPUMASK bit 4.
- i_show_left8  in  1  PPUMASK bit 2; show sprites in columns 0-7.
- i_load  in  1  Load strobe from the fetch stage.
- i_load_slot  in  3  Target slot, 0-7.
- i_load_attr  in  8  OAM byte 2.
- i_load_x  in  8  OAM byte 3.
- i_load_lo  in  8  Pattern plane 0 as fetched.
- i_load_hi  in  8  Pattern plane 1 as fetched.
- i_sprite0_in_slot0  in  1  Sprite 0 was copied to secondary OAM slot 0; sampled on the slot-0 load.
- o_palette_index  out  4  {attr[1:0], pixel[1:0]}; 0 means transparent. Reset value 0.
- o_priority  out  1  Winning sprite's attr[5], behind background. Reset value 0.
- o_sprite0_opaque  out  1  Slot 0 holds sprite 0 and its pixel is opaque. Reset value 0.

## Operation
- Per slot: 8-bit lo/hi shift registers, 8-bit X down-counter, 3-bit attribute (palette[1:0], priority). Slot 0 also holds a sprite-0 flag.
- Load (i_ce && i_load): the addressed slot captures X, attributes and patterns.
  - If attr[6] (horizontal flip) is set, the lo/hi bytes are bit-reversed on load. The shift-out is always MSB-first.
  - attr[7] (vertical flip) is ignored here; the fetch stage handles it.
- Clear: on the i_ce cycle with i_video_x == 257, every slot's patterns, X and attributes clear to 0. A load in the same cycle wins for its slot. Slots never loaded therefore stay transparent.
- Render: on each i_ce cycle with 1 <= i_video_x <= 256, every slot evaluates column c = i_video_x-1:
  - If the counter is nonzero, the slot decrements it and outputs a transparent pixel.
  - If the counter is 0, the slot outputs {hi[7], lo[7]} and shifts both registers left, filling with 0.
  - Counter width is 8 bits. X = 0 shows from column 0. X = 255 shows only column 255. Counters never wrap below 0.
- Select: the lowest-numbered slot with a nonzero pixel wins and drives the index and priority.
  - o_sprite0_opaque depends only on slot 0 and is independent of which slot wins.
- Masking forces the result transparent (index 0, priority 0, sprite0 0) when sprites are disabled. Shifting and counting still continue.
- Outside dots 1-256 the outputs are driven to 0 on the next i_ce.
- Reset at any time clears all slots and outputs. Rendering resumes at the next load and scanline.

## Timing
- Output is registered with one-cycle latency. The pixel for column c appears on the i_ce cycle after i_video_x = c+1 and holds until the next i_ce.
- A load takes effect on the next i_ce. Loads at dots 257-320 do not disturb the outputs, which are 0 at those dots.
- When i_ce is low, all state and outputs hold.

## Configuration
- PPU_SPRITE_LEFT_CLIP_EN defined: when i_show_left8 == 0, columns 0-7 are forced transparent, including o_sprite0_opaque.
- Not defined: i_show_left8 is ignored and columns 0-7 render normally.

## Structure
- Package ppu_sprite_pkg holds:
  - SPRITE_SLOTS = 8.
  - Attribute bit indices: ATTR_PAL_LO = 0, ATTR_PRIORITY = 5, ATTR_FLIP_H = 6, ATTR_FLIP_V = 7.
  - Visible-range constants: 1 and 256.
  - Clear dot 257.
- Sub-module sprite_output_unit is one slot, holding the counter, shifters, attribute and flip logic. It is instantiated 8 times. Top level holds the priority mux, masking and output registers.

## Test plan
- Slot 3 loaded with X = 10, lo = 8'hF0, hi = 8'h00, palette 2 -> columns 10-13 give index 4'b1001; columns 14-17 and 0-9 give 0.
- Slot 3 same load with attr[6] = 1 -> index 4'b1001 only at columns 14-17.
- Slot 1 (X = 20, hi = 8'hFF, lo = 0, palette 0, priority 1) and slot 5 (X = 20, lo = 8'hFF, palette 3) -> columns 20-27 give index 4'b0010 and o_priority = 1. Clearing slot 1's pattern gives 4'b1101 and o_priority = 0.
- Sprite 0 in slot 0 at X = 4, lo = 8'h80, macro defined, i_show_left8 = 0 -> o_sprite0_opaque stays 0. With i_show_left8 = 1 it pulses for exactly column 4.
- Slot 7 at X = 255, lo = 8'hFF -> only column 255 is opaque. The next scanline without a reload is fully transparent because of the clear at dot 257.
- Reset asserted mid-row while column 12 is opaque -> outputs are 0 the next cycle and stay transparent for the rest of the row.
